uart_tx_divclk: RTL and testbench

UART transmitter that consumes the square-wave output of the clock divider as its baud reference. It detects rising edges of the divided clock inside the `iwClk` domain, turning each edge into a one-cycle bit-time tick. It serialises one parallel byte per valid/ready handshake onto a single TX line: start bit, LSB-first data, stop bit(s). It sits between the CPU-side I/O register and the board UART pin.

---
 rtl/uart_tx_divclk_pkg.sv | 20 ++
 rtl/uart_tx_divclk_edge_tick.sv | 35 +++
 rtl/uart_tx_divclk.sv | 124 ++++++++++++
 tb/tb_uart_tx_divclk.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_divclk_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_divclk_pkg
//   Shared constants for the divided-clock UART transmitter (and the future
//   receiver that will reuse edge_tick).
//   - FSM state encodings, 3 bits wide, kept as plain localparam constants so
//     they match the legacy header values (IDLE=0 .. STOP=4).
//   - Idle level of the serial line.
// ---------------------------------------------------------------------------
package uart_tx_divclk_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // A UART line rests at mark (logic high) between frames.
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_divclk_edge_tick.sv
// ---------------------------------------------------------------------------
// edge_tick
//   Registered rising-edge detector. Turns a square wave that is already
//   generated in the iwClk domain into a one-cycle tick.
//   Ports:
//     iwClk   - system clock, rising edge
//     iwnRst  - asynchronous active-low reset
//     iwSig   - input square wave (iwClk-domain register output)
//     owTick  - high for the one cycle in which iwSig has just risen
//   pRstVal sets the reset value of the delay register. Resetting it to 1
//   means a signal that is already high at reset release does not produce a
//   spurious tick.
// ---------------------------------------------------------------------------
module edge_tick #(
    parameter logic pRstVal = 1'b1
) (
    input  logic iwClk,
    input  logic iwnRst,
    input  logic iwSig,
    output logic owTick
);

    logic rSigQ;

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rSigQ <= pRstVal;
        end else begin
            rSigQ <= iwSig;
        end
    end

    assign owTick = iwSig & ~rSigQ;

endmodule

// File: rtl/uart_tx_divclk.sv
// ---------------------------------------------------------------------------
// uart_tx_divclk
//   UART transmitter timed by the divided-clock square wave. Each rising edge
//   of iwDivClk becomes one bit-time tick; a byte accepted on a valid/ready
//   handshake is sent as start bit, LSB-first data, then stop bit(s).
//   Ports:
//     iwClk     - system clock, rising edge
//     iwnRst    - asynchronous active-low reset
//     iwDivClk  - baud square wave, registered in the iwClk domain
//     iwValid   - transmit request
//     iwData    - word to send, sampled only on the handshake
//     owReady   - combinational, high while idle
//     orTx      - serial line, idle high
//     orBusy    - high from the handshake until the last stop bit ends
//   Parameters: pDataBits (5..9), pStopBits (1 or 2).
// ---------------------------------------------------------------------------
module uart_tx_divclk
    import uart_tx_divclk_pkg::*;
#(
    parameter int pDataBits = 8,
    parameter int pStopBits = 1
) (
    input  logic                 iwClk,
    input  logic                 iwnRst,
    input  logic                 iwDivClk,
    input  logic                 iwValid,
    input  logic [pDataBits-1:0] iwData,
    output logic                 owReady,
    output logic                 orTx,
    output logic                 orBusy
);

    localparam int                cIdxW    = (pDataBits > 1) ? $clog2(pDataBits) : 1;
    localparam logic [cIdxW-1:0]  cLastIdx = cIdxW'(pDataBits - 1);
    localparam logic              cLastStp = 1'(pStopBits - 1);

    logic                 wTick;
    logic [2:0]           rState;
    logic [pDataBits-1:0] rShift;
    logic [cIdxW-1:0]     rBitIdx;
    logic                 rStopCnt;

    // iwDivClk comes straight from a register in this clock domain, so the
    // edge detector samples it directly without a synchroniser.
    edge_tick #(
        .pRstVal (1'b1)
    ) uDivTick (
        .iwClk  (iwClk),
        .iwnRst (iwnRst),
        .iwSig  (iwDivClk),
        .owTick (wTick)
    );

    assign owReady = (rState == ST_IDLE);

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rState   <= ST_IDLE;
            rShift   <= '0;
            rBitIdx  <= '0;
            rStopCnt <= 1'b0;
            orTx     <= LINE_IDLE;
            orBusy   <= 1'b0;
        end else begin
            case (rState)
                // Ticks are deliberately ignored here: the WAIT state exists
                // so the start bit always begins on a tick and lasts a full
                // bit period, even if a tick coincides with the handshake.
                ST_IDLE: begin
                    if (iwValid) begin
                        rShift <= iwData;
                        orBusy <= 1'b1;
                        rState <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wTick) begin
                        orTx   <= 1'b0;
                        rState <= ST_START;
                    end
                end
                ST_START: begin
                    if (wTick) begin
                        orTx    <= rShift[0];
                        rShift  <= rShift >> 1;
                        rBitIdx <= '0;
                        rState  <= ST_DATA;
                    end
                end
                // rBitIdx counts data bits already on the line; once the
                // last one has had its full period the line goes to stop.
                ST_DATA: begin
                    if (wTick) begin
                        if (rBitIdx == cLastIdx) begin
                            orTx     <= LINE_IDLE;
                            rStopCnt <= 1'b0;
                            rState   <= ST_STOP;
                        end else begin
                            orTx    <= rShift[0];
                            rShift  <= rShift >> 1;
                            rBitIdx <= rBitIdx + cIdxW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (wTick) begin
                        if (rStopCnt == cLastStp) begin
                            orBusy <= 1'b0;
                            rState <= ST_IDLE;
                        end else begin
                            rStopCnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    orTx   <= LINE_IDLE;
                    orBusy <= 1'b0;
                    rState <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_divclk.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_divclk
//   Directed bench for uart_tx_divclk. Two instances: 8N1 (sel=0) and 8N2
//   (sel=1). The divided clock has period P = 6 system cycles and is produced
//   here; the bench keeps its own copy of the previous divided-clock level to
//   know when a tick is due.
// ---------------------------------------------------------------------------
module tb_uart_tx_divclk;

    logic       iwClk;
    logic       iwnRst;
    logic       iwValid;
    logic [7:0] iwData;
    logic       sel;

    logic divRun;
    logic divClk  = 1'b1;
    logic divPrev = 1'b1;
    int   divCnt  = 0;

    logic validA, validB;
    logic readyA, txA, busyA;
    logic readyB, txB, busyB;
    logic ready, tx, busy;

    int vectors     = 0;
    int miscompares = 0;
    int w;

    assign validA = iwValid & ~sel;
    assign validB = iwValid & sel;
    assign ready  = sel ? readyB : readyA;
    assign tx     = sel ? txB    : txA;
    assign busy   = sel ? busyB  : busyA;

    uart_tx_divclk #(.pDataBits(8), .pStopBits(1)) dutA (
        .iwClk    (iwClk),
        .iwnRst   (iwnRst),
        .iwDivClk (divClk),
        .iwValid  (validA),
        .iwData   (iwData),
        .owReady  (readyA),
        .orTx     (txA),
        .orBusy   (busyA)
    );

    uart_tx_divclk #(.pDataBits(8), .pStopBits(2)) dutB (
        .iwClk    (iwClk),
        .iwnRst   (iwnRst),
        .iwDivClk (divClk),
        .iwValid  (validB),
        .iwData   (iwData),
        .owReady  (readyB),
        .orTx     (txB),
        .orBusy   (busyB)
    );

    initial iwClk = 1'b0;
    always #5 iwClk = ~iwClk;

    // Divided clock: held high while divRun is low, else period 6, high 3.
    always @(posedge iwClk) begin
        divPrev <= divClk;
        if (!divRun) begin
            divCnt <= 0;
            divClk <= 1'b1;
        end else begin
            divCnt <= (divCnt == 5) ? 0 : divCnt + 1;
            divClk <= (divCnt >= 2 && divCnt <= 4);
        end
    end

    function automatic logic tickNow();
        return divClk & ~divPrev;
    endfunction

    task automatic step();
        @(posedge iwClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic hs(input logic [7:0] d);
        iwValid = 1'b1;
        iwData  = d;
        step();
        iwValid = 1'b0;
        chk("busy after handshake", busy, 1'b1);
        chk("ready after handshake", ready, 1'b0);
    endtask

    // Waits for the start edge; it must land on the first tick after the
    // handshake. n returns the number of cycles waited.
    task automatic waitStart(input bit poke, output int n);
        bit   found;
        logic t;
        found = 0;
        n = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            t = tickNow();
            if (poke) begin
                iwValid = 1'b1;
                iwData  = 8'hFF;
            end
            step();
            n++;
            if (t) begin
                found = 1;
                chk("start bit on first tick", tx, 1'b0);
            end else begin
                chk("line high while waiting", tx, 1'b1);
            end
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL start timeout: observed no start edge expected one within 20 cycles");
        end
    endtask

    task automatic checkFrame(input logic [7:0] d, input int nstop, input bit poke,
                              output int n);
        int   nbits;
        int   k;
        logic e;
        waitStart(poke, n);
        nbits = 9 + nstop;
        for (int c = 0; c < nbits * 6; c++) begin
            if (poke) begin
                iwValid = (c < 40);
                iwData  = 8'hFF;
            end
            k = c / 6;
            if (k == 0)      e = 1'b0;
            else if (k <= 8) e = d[k-1];
            else             e = 1'b1;
            chk($sformatf("line d=%02h cyc%0d", d, c), tx, e);
            chk($sformatf("busy in frame cyc%0d", c), busy, 1'b1);
            chk($sformatf("ready in frame cyc%0d", c), ready, 1'b0);
            step();
        end
        iwValid = 1'b0;
        chk("ready at frame end", ready, 1'b1);
        chk("busy at frame end", busy, 1'b0);
        chk("line at frame end", tx, 1'b1);
    endtask

    initial begin
        iwnRst  = 1'b0;
        iwValid = 1'b0;
        iwData  = 8'h00;
        sel     = 1'b0;
        divRun  = 1'b0;
        repeat (3) step();

        // Reset values, with the divided clock held high through release.
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset ready", ready, 1'b1);
        iwnRst = 1'b1;
        repeat (4) begin
            step();
            chk("idle tx A", txA, 1'b1);
            chk("idle ready A", readyA, 1'b1);
            chk("idle busy B", busyB, 1'b0);
        end

        // 0x55 at 8N1: no tick while divClk stays high, then a normal frame.
        hs(8'h55);
        repeat (12) begin
            step();
            chk("no tick with divclk held high", tx, 1'b1);
        end
        divRun = 1'b1;
        checkFrame(8'h55, 1, 1'b0, w);

        // 0xA3 with 0xFF requested throughout the frame.
        hs(8'hA3);
        checkFrame(8'hA3, 1, 1'b1, w);
        chk("wait within one period", (w >= 1 && w <= 6), 1'b1);

        // 0x00 at 8N2: 54 cycles low, 12 high.
        sel = 1'b1;
        hs(8'h00);
        checkFrame(8'h00, 2, 1'b0, w);
        sel = 1'b0;

        // Reset asserted during data bit 3 of 0xF0 (a low bit).
        hs(8'hF0);
        waitStart(1'b0, w);
        repeat (26) step();
        chk("data bit 3 before reset", tx, 1'b0);
        iwnRst = 1'b0;
        #1;
        chk("async reset tx", tx, 1'b1);
        chk("async reset busy", busy, 1'b0);
        chk("async reset ready", ready, 1'b1);
        step();
        step();
        iwnRst = 1'b1;
        hs(8'h0F);
        checkFrame(8'h0F, 1, 1'b0, w);

        // Handshake in the same cycle as a tick: start comes a period later.
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (tickNow()) found = 1;
                else step();
            end
            vectors++;
            assert (found) else begin
                miscompares++;
                $error("FAIL tick search: observed no tick expected one within 20 cycles");
            end
        end
        hs(8'h96);
        checkFrame(8'h96, 1, 1'b0, w);
        chk("handshake-on-tick waits 6 cycles", (w == 6), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
